hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Central stall/flush sequencer for the five-stage pipelined-plus-cache RISC-V core. It drives the per-stage enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazard sources: load-use dependencies, taken branches/jumps, and data-cache misses (via a miss-sequencing FSM). It also keeps a stall-cycle performance counter and a sticky miss-timeout error.

## Interface
- DATA_WIDTH, 32, width of the performance counter.
- REG_ADDR_WIDTH, 5, register index width.
- MISS_TIMEOUT, 255, maximum cycles in MISS before `err_timeout` sets.

- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- Rs1_d, Rs2_d  in  REG_ADDR_WIDTH  source registers of the instruction in decode
- Rd_e  in  REG_ADDR_WIDTH  destination of the instruction in execute
- ResultSrc_e  in  2  2'b01 marks a load in execute
- RegWrite_e, valid_e  in  1  execute-stage write enable / valid
- PCSrc_e  in  1  taken branch/jump resolved in execute
- mem_req_m  in  1  valid load/store in memory stage
- cache_hit_m  in  1  data-cache hit for the current access
- refill_done  in  1  single-cycle pulse: line refill complete
- refill_req  out  1  single-cycle pulse: start a line refill
- en_f, en_d, en_e, en_m, en_w  out  1  stage-register enables (0 = hold)
- flush_d, flush_e  out  1  active-high: load a bubble into IF/ID or ID/EX at next edge
- valid_w  out  1  valid into the MEM/WB register
- stall_cycles  out  DATA_WIDTH  count of cycles with `en_f` low
- err_timeout  out  1  sticky miss-timeout flag

## Operation
- **Miss FSM states:** IDLE, MISS, REPLAY.
  - IDLE → MISS when `mem_req_m && !cache_hit_m`. `refill_req` pulses in that same cycle.
  - MISS → REPLAY on `refill_done`.
  - REPLAY → IDLE unconditionally.
- **`miss_stall`** = (IDLE && `mem_req_m` && !`cache_hit_m`) || MISS || REPLAY.
- **`load_use`** = `valid_e` && `RegWrite_e` && `ResultSrc_e` == 2'b01 && `Rd_e` != 0 && (`Rd_e` == `Rs1_d` || `Rd_e` == `Rs2_d`).
- **`redirect`** = `valid_e` && `PCSrc_e`.
- **Priority is miss_stall > redirect > load_use.**
  - miss_stall: all `en_*` = 0, flushes = 0, `valid_w` = 0. The frozen branch re-resolves after the stall.
  - redirect: all `en_*` = 1, `flush_d` = 1, `flush_e` = 1. Any concurrent load_use belongs to the wrong path and is ignored.
  - load_use: `en_f` = `en_d` = 0, `flush_e` = 1, `en_e`/`en_m`/`en_w` = 1.
  - Otherwise: all `en_*` = 1, flushes = 0, `valid_w` = 1.
- **Counters:**
  - `stall_cycles` increments by 1 every cycle `en_f` is 0 and wraps modulo 2^DATA_WIDTH.
  - The timeout counter clears on entry to MISS and increments each MISS cycle. `err_timeout` sets when it reaches MISS_TIMEOUT. The FSM keeps waiting on `refill_done`.
- **Reset values:**
  - FSM = IDLE; `stall_cycles` = 0; timeout counter = 0; `err_timeout` = 0; `refill_req` = 0.
  - Combinational outputs follow the rules above with state IDLE.

## Timing
- Enable and flush outputs are combinational from inputs and state, so they are valid in the detection cycle. Consumers act on them at the next rising edge.
- **Miss detected in cycle t:**
  - Stall in t.
  - MISS from t+1.
  - `refill_done` in t+k → REPLAY in t+k+1 (stalled).
  - IDLE in t+k+2. `cache_hit_m` is expected to be 1, and the pipeline advances at the end of t+k+2.
  - Total stall = k+2 cycles.
- `refill_done` in the same cycle the miss is detected (still IDLE) is ignored.
- `refill_req` fires only on the IDLE → MISS transition, never while in MISS or REPLAY.
- Load-use costs exactly 1 bubble cycle; redirect costs 2 squashed slots.
- **`rst` mid-miss:**
  - Next state is IDLE and `refill_req` is 0.
  - Counters clear and no REPLAY occurs.
  - A `refill_done` pulse arriving after reset is ignored.

## Structure
- Shared package `hazard_pkg`:
  - typedef `miss_state_t` {IDLE, MISS, REPLAY}
  - constant `RESULT_SRC_LOAD` = 2'b01
- Sub-module `miss_fsm` holds the state register, `refill_req` and the timeout counter.
- The top level holds the priority logic and `stall_cycles`.

## Test plan
- **Load-use:** lw x5 in E (`Rd_e` = 5, `ResultSrc_e` = 01), `Rs1_d` = 5 → one cycle `en_f` = `en_d` = 0, `flush_e` = 1; next cycle all enables 1; `stall_cycles` = 1.
- **x0 / no-write:** `Rd_e` = 0 or `RegWrite_e` = 0 with a matching Rs → no stall.
- **Redirect + load_use same cycle:** `flush_d` = `flush_e` = 1, all `en_*` = 1, `stall_cycles` unchanged.
- **Cache miss, `refill_done` 10 cycles after detection:**
  - `refill_req` pulses once.
  - All `en_*` = 0 for 12 cycles and `valid_w` = 0 throughout.
  - Then IDLE with hit → normal flow; `stall_cycles` = 12.
- **Timeout (MISS_TIMEOUT = 4, no `refill_done`):** `err_timeout` sets after 4 MISS cycles and stays set; a later `refill_done` completes the REPLAY → IDLE sequence.
- **Reset in MISS:** assert `rst` one cycle → IDLE, counters 0, enables 1; a stray `refill_done` afterwards causes no transition.

Source files
------------

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the hazard controller slice.
//   miss_state_t    : data-cache miss sequencer states
//   RESULT_SRC_LOAD : ResultSrc encoding that marks a load in execute
//   f_is_load       : decodes ResultSrc into a load flag
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    MISS   = 2'b01,
    REPLAY = 2'b10
  } miss_state_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  function automatic logic f_is_load(input logic [1:0] result_src);
    return (result_src == RESULT_SRC_LOAD);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundles the pipeline-facing hazard signals.
//   master : pipeline/cache side (drives hazard sources, observes controls)
//   slave  : hazard controller side (observes sources, drives controls)
// Signals:
//   Rs1_d, Rs2_d, Rd_e, ResultSrc_e, RegWrite_e, valid_e, PCSrc_e : decode/execute info
//   mem_req_m, cache_hit_m, refill_done                            : memory stage / cache
//   refill_req                                                     : refill start pulse
//   en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, valid_w        : stage controls
//   stall_cycles, err_timeout                                      : perf counter, sticky error
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);

  logic [REG_ADDR_WIDTH-1:0] Rs1_d;
  logic [REG_ADDR_WIDTH-1:0] Rs2_d;
  logic [REG_ADDR_WIDTH-1:0] Rd_e;
  logic [1:0]                ResultSrc_e;
  logic                      RegWrite_e;
  logic                      valid_e;
  logic                      PCSrc_e;
  logic                      mem_req_m;
  logic                      cache_hit_m;
  logic                      refill_done;
  logic                      refill_req;
  logic                      en_f;
  logic                      en_d;
  logic                      en_e;
  logic                      en_m;
  logic                      en_w;
  logic                      flush_d;
  logic                      flush_e;
  logic                      valid_w;
  logic [DATA_WIDTH-1:0]     stall_cycles;
  logic                      err_timeout;

  modport master (
    output Rs1_d, Rs2_d, Rd_e, ResultSrc_e, RegWrite_e, valid_e, PCSrc_e,
    output mem_req_m, cache_hit_m, refill_done,
    input  refill_req, en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, valid_w,
    input  stall_cycles, err_timeout
  );

  modport slave (
    input  Rs1_d, Rs2_d, Rd_e, ResultSrc_e, RegWrite_e, valid_e, PCSrc_e,
    input  mem_req_m, cache_hit_m, refill_done,
    output refill_req, en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, valid_w,
    output stall_cycles, err_timeout
  );

endinterface

// File: rtl/hazard_ctrl_miss_fsm.sv
// -----------------------------------------------------------------------------
// miss_fsm
// Data-cache miss sequencer: IDLE -> MISS on a missing access, MISS -> REPLAY
// on refill completion, REPLAY -> IDLE. Also owns the miss timeout counter and
// the sticky timeout error.
// Ports:
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_mem_req         : valid load/store in memory stage
//   i_cache_hit       : cache hit for the current access
//   i_refill_done     : refill complete pulse
//   o_miss_stall      : pipeline must freeze this cycle
//   o_refill_req      : refill start pulse (IDLE -> MISS only)
//   o_err_timeout     : sticky timeout flag
// -----------------------------------------------------------------------------
module miss_fsm
  import hazard_pkg::*;
#(
  parameter int MISS_TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_mem_req,
  input  logic i_cache_hit,
  input  logic i_refill_done,
  output logic o_miss_stall,
  output logic o_refill_req,
  output logic o_err_timeout
);

  localparam int CNT_W = $clog2(MISS_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MISS_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MISS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  miss_state_t       r_state;
  miss_state_t       w_state_nxt;
  logic [CNT_W-1:0]  r_to_cnt;
  logic              r_err_timeout;
  logic              w_miss_detect;

  // A refill_done in the detection cycle is ignored because only MISS reacts to it.
  assign w_miss_detect = (r_state == IDLE) && i_mem_req && !i_cache_hit;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = IDLE;
    case (r_state)
      IDLE: begin
        if (w_miss_detect) begin
          w_state_nxt = MISS;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      MISS: begin
        if (i_refill_done) begin
          w_state_nxt = REPLAY;
        end else begin
          w_state_nxt = MISS;
        end
      end
      REPLAY:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode; an illegal encoding stalls until the FSM recovers to IDLE.
  always_comb begin
    o_miss_stall = 1'b1;
    o_refill_req = 1'b0;
    case (r_state)
      IDLE: begin
        o_miss_stall = w_miss_detect;
        o_refill_req = w_miss_detect && !i_rst;
      end
      MISS: begin
        o_miss_stall = 1'b1;
        o_refill_req = 1'b0;
      end
      REPLAY: begin
        o_miss_stall = 1'b1;
        o_refill_req = 1'b0;
      end
      default: begin
        o_miss_stall = 1'b1;
        o_refill_req = 1'b0;
      end
    endcase
  end

  // Timeout counter: cleared on MISS entry, saturating count of MISS cycles;
  // the error latches on the edge that brings the count to MISS_TIMEOUT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_to_cnt      <= CNT_ZERO;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_miss_detect) begin
        r_to_cnt <= CNT_ZERO;
      end else if ((r_state == MISS) && (r_to_cnt != CNT_MAX)) begin
        r_to_cnt <= r_to_cnt + CNT_ONE;
      end else begin
        r_to_cnt <= r_to_cnt;
      end
      if ((r_state == MISS) && (r_to_cnt == CNT_LAST)) begin
        r_err_timeout <= 1'b1;
      end else begin
        r_err_timeout <= r_err_timeout;
      end
    end
  end

  assign o_err_timeout = r_err_timeout;

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Central stall/flush sequencer. Combines cache-miss stalls, branch redirects
// and load-use hazards (priority in that order) into per-stage enables and
// flushes, and counts cycles in which fetch is held.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : hazard_ctrl_if.slave (sources in, stage controls/counters out)
// -----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MISS_TIMEOUT   = 255
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  localparam logic [REG_ADDR_WIDTH-1:0] X0_REG   = {REG_ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0]     CNT_ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0]     CNT_ZERO = {DATA_WIDTH{1'b0}};

  logic                  w_miss_stall;
  logic                  w_refill_req;
  logic                  w_err_timeout;
  logic                  w_load_use;
  logic                  w_redirect;
  logic                  w_en_f;
  logic                  w_en_d;
  logic                  w_en_e;
  logic                  w_en_m;
  logic                  w_en_w;
  logic                  w_flush_d;
  logic                  w_flush_e;
  logic                  w_valid_w;
  logic [DATA_WIDTH-1:0] r_stall_cycles;

  miss_fsm #(
    .MISS_TIMEOUT (MISS_TIMEOUT)
  ) u_miss_fsm (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_mem_req     (bus.mem_req_m),
    .i_cache_hit   (bus.cache_hit_m),
    .i_refill_done (bus.refill_done),
    .o_miss_stall  (w_miss_stall),
    .o_refill_req  (w_refill_req),
    .o_err_timeout (w_err_timeout)
  );

  // Writes to x0 never create a dependency.
  assign w_load_use = bus.valid_e && bus.RegWrite_e && f_is_load(bus.ResultSrc_e) &&
                      (bus.Rd_e != X0_REG) &&
                      ((bus.Rd_e == bus.Rs1_d) || (bus.Rd_e == bus.Rs2_d));

  assign w_redirect = bus.valid_e && bus.PCSrc_e;

  // Priority resolution: a miss freezes everything (the branch re-resolves
  // later), a redirect squashes the wrong-path load-use, load-use bubbles EX.
  always_comb begin
    w_en_f    = 1'b1;
    w_en_d    = 1'b1;
    w_en_e    = 1'b1;
    w_en_m    = 1'b1;
    w_en_w    = 1'b1;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_valid_w = 1'b1;
    if (w_miss_stall) begin
      w_en_f    = 1'b0;
      w_en_d    = 1'b0;
      w_en_e    = 1'b0;
      w_en_m    = 1'b0;
      w_en_w    = 1'b0;
      w_valid_w = 1'b0;
    end else if (w_redirect) begin
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
    end else if (w_load_use) begin
      w_en_f    = 1'b0;
      w_en_d    = 1'b0;
      w_flush_e = 1'b1;
    end else begin
      w_en_f    = 1'b1;
      w_en_d    = 1'b1;
    end
  end

  // Performance counter of fetch-held cycles, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= CNT_ZERO;
    end else if (!w_en_f) begin
      r_stall_cycles <= r_stall_cycles + CNT_ONE;
    end else begin
      r_stall_cycles <= r_stall_cycles;
    end
  end

  assign bus.en_f         = w_en_f;
  assign bus.en_d         = w_en_d;
  assign bus.en_e         = w_en_e;
  assign bus.en_m         = w_en_m;
  assign bus.en_w         = w_en_w;
  assign bus.flush_d      = w_flush_d;
  assign bus.flush_e      = w_flush_e;
  assign bus.valid_w      = w_valid_w;
  assign bus.refill_req   = w_refill_req;
  assign bus.err_timeout  = w_err_timeout;
  assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Scoreboard bench: the driver applies stimulus #1 after each rising edge,
// derives the expected outputs from a behavioural model and queues them; a
// monitor pops and compares on each falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int MT = 4;

  typedef struct {
    logic        en_f, en_d, en_e, en_m, en_w;
    logic        flush_d, flush_e, valid_w, refill_req, err;
    logic [31:0] stalls;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

  hazard_ctrl #(
    .DATA_WIDTH     (32),
    .REG_ADDR_WIDTH (5),
    .MISS_TIMEOUT   (MT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   pulse_cnt = 0;
  exp_t q[$];
  exp_t mon_e;

  logic       s_rst, s_rw, s_ve, s_pc, s_mreq, s_hit, s_rdone;
  logic [4:0] s_rs1, s_rs2, s_rd;
  logic [1:0] s_rsrc;

  // Model state: waiting for refill, one replay cycle pending, MISS cycle count.
  bit          m_waiting, m_replay, m_err;
  int          m_miss_cycles;
  logic [31:0] m_stalls;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic set_idle();
    s_rst = 1'b0; s_rs1 = 5'd0; s_rs2 = 5'd0; s_rd = 5'd0; s_rsrc = 2'b00;
    s_rw = 1'b0; s_ve = 1'b0; s_pc = 1'b0; s_mreq = 1'b0; s_hit = 1'b1; s_rdone = 1'b0;
  endtask

  task automatic model_clear();
    m_waiting = 1'b0; m_replay = 1'b0; m_err = 1'b0;
    m_miss_cycles = 0; m_stalls = 32'd0;
  endtask

  // One clock cycle: apply stimulus, queue expectation, advance the model.
  task automatic step();
    exp_t e;
    bit detect, mstall, lu, redir;
    @(posedge clk);
    #1;
    rst = s_rst;
    bus.Rs1_d = s_rs1; bus.Rs2_d = s_rs2; bus.Rd_e = s_rd; bus.ResultSrc_e = s_rsrc;
    bus.RegWrite_e = s_rw; bus.valid_e = s_ve; bus.PCSrc_e = s_pc;
    bus.mem_req_m = s_mreq; bus.cache_hit_m = s_hit; bus.refill_done = s_rdone;

    detect = !m_waiting && !m_replay && s_mreq && !s_hit;
    mstall = detect || m_waiting || m_replay;
    lu     = s_ve && s_rw && (s_rsrc == 2'b01) && (s_rd != 5'd0) &&
             ((s_rd == s_rs1) || (s_rd == s_rs2));
    redir  = s_ve && s_pc;

    e.en_f = 1'b1; e.en_d = 1'b1; e.en_e = 1'b1; e.en_m = 1'b1; e.en_w = 1'b1;
    e.flush_d = 1'b0; e.flush_e = 1'b0; e.valid_w = 1'b1;
    if (mstall) begin
      e.en_f = 1'b0; e.en_d = 1'b0; e.en_e = 1'b0; e.en_m = 1'b0; e.en_w = 1'b0;
      e.valid_w = 1'b0;
    end else if (redir) begin
      e.flush_d = 1'b1; e.flush_e = 1'b1;
    end else if (lu) begin
      e.en_f = 1'b0; e.en_d = 1'b0; e.flush_e = 1'b1;
    end
    e.refill_req = detect && !s_rst;
    e.err        = m_err;
    e.stalls     = m_stalls;
    e.cyc        = cyc;
    q.push_back(e);

    if (s_rst) begin
      model_clear();
    end else begin
      if (!e.en_f) m_stalls = m_stalls + 32'd1;
      if (m_replay) begin
        m_replay = 1'b0;
      end else if (m_waiting) begin
        m_miss_cycles++;
        if (m_miss_cycles == MT) m_err = 1'b1;
        if (s_rdone) begin
          m_waiting = 1'b0;
          m_replay  = 1'b1;
        end
      end else if (detect) begin
        m_waiting     = 1'b1;
        m_miss_cycles = 0;
      end
    end
    cyc++;
    #3;
    if (bus.refill_req === 1'b1) pulse_cnt++;
  endtask

  // Monitor: compares every presented cycle against the queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("en_f",         {31'd0, bus.en_f},        {31'd0, mon_e.en_f});
        chk("en_d",         {31'd0, bus.en_d},        {31'd0, mon_e.en_d});
        chk("en_e",         {31'd0, bus.en_e},        {31'd0, mon_e.en_e});
        chk("en_m",         {31'd0, bus.en_m},        {31'd0, mon_e.en_m});
        chk("en_w",         {31'd0, bus.en_w},        {31'd0, mon_e.en_w});
        chk("flush_d",      {31'd0, bus.flush_d},     {31'd0, mon_e.flush_d});
        chk("flush_e",      {31'd0, bus.flush_e},     {31'd0, mon_e.flush_e});
        chk("valid_w",      {31'd0, bus.valid_w},     {31'd0, mon_e.valid_w});
        chk("refill_req",   {31'd0, bus.refill_req},  {31'd0, mon_e.refill_req});
        chk("err_timeout",  {31'd0, bus.err_timeout}, {31'd0, mon_e.err});
        chk("stall_cycles", bus.stall_cycles,         mon_e.stalls);
      end
    end
  end

  initial begin
    model_clear();
    set_idle();
    rst = 1'b1;
    bus.Rs1_d = 5'd0; bus.Rs2_d = 5'd0; bus.Rd_e = 5'd0; bus.ResultSrc_e = 2'b00;
    bus.RegWrite_e = 1'b0; bus.valid_e = 1'b0; bus.PCSrc_e = 1'b0;
    bus.mem_req_m = 1'b0; bus.cache_hit_m = 1'b1; bus.refill_done = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state.
    s_rst = 1'b1; step();
    set_idle(); step();

    // Load-use: one bubble, then normal flow, one stall cycle counted.
    s_ve = 1'b1; s_rw = 1'b1; s_rsrc = 2'b01; s_rd = 5'd5; s_rs1 = 5'd5; step();
    chk("lu_en_f", {31'd0, bus.en_f}, 32'd0);
    chk("lu_flush_e", {31'd0, bus.flush_e}, 32'd1);
    set_idle(); step();
    chk("lu_after_en_f", {31'd0, bus.en_f}, 32'd1);
    chk("lu_stall_cnt", bus.stall_cycles, 32'd1);

    // x0 destination and non-writing instruction never stall.
    s_ve = 1'b1; s_rw = 1'b1; s_rsrc = 2'b01; s_rd = 5'd0; s_rs1 = 5'd0; step();
    chk("x0_en_f", {31'd0, bus.en_f}, 32'd1);
    s_rw = 1'b0; s_rd = 5'd7; s_rs2 = 5'd7; step();
    chk("nowrite_en_f", {31'd0, bus.en_f}, 32'd1);

    // Redirect wins over load-use.
    set_idle(); s_ve = 1'b1; s_rw = 1'b1; s_rsrc = 2'b01; s_rd = 5'd9; s_rs2 = 5'd9; s_pc = 1'b1;
    step();
    chk("redir_flush_d", {31'd0, bus.flush_d}, 32'd1);
    chk("redir_en_d", {31'd0, bus.en_d}, 32'd1);
    set_idle(); step();
    chk("redir_stall_cnt", bus.stall_cycles, 32'd1);

    // Cache miss with refill_done 10 cycles after detection: 12 stall cycles.
    s_rst = 1'b1; step();
    set_idle(); step();
    pulse_cnt = 0;
    s_mreq = 1'b1; s_hit = 1'b0; step();
    for (int i = 1; i < 10; i++) begin
      step();
      chk("miss_en_f", {31'd0, bus.en_f}, 32'd0);
      chk("miss_valid_w", {31'd0, bus.valid_w}, 32'd0);
    end
    s_rdone = 1'b1; step();
    s_rdone = 1'b0; step();
    chk("replay_en_w", {31'd0, bus.en_w}, 32'd0);
    s_hit = 1'b1; step();
    chk("miss_done_en_f", {31'd0, bus.en_f}, 32'd1);
    chk("miss_pulses", pulse_cnt, 32'd1);
    set_idle(); step();
    chk("miss_stall_cnt", bus.stall_cycles, 32'd12);

    // Timeout with no refill_done, then a late refill_done completes the miss.
    s_rst = 1'b1; step();
    set_idle(); step();
    s_mreq = 1'b1; s_hit = 1'b0; step();
    set_idle();
    repeat (3) step();
    chk("to_not_yet", {31'd0, bus.err_timeout}, 32'd0);
    repeat (3) step();
    chk("to_set", {31'd0, bus.err_timeout}, 32'd1);
    s_rdone = 1'b1; step();
    s_rdone = 1'b0; step();
    step();
    chk("to_idle_en_f", {31'd0, bus.en_f}, 32'd1);
    chk("to_sticky", {31'd0, bus.err_timeout}, 32'd1);

    // Reset while in MISS; a stray refill_done afterwards does nothing.
    s_rst = 1'b1; step();
    set_idle(); step();
    s_mreq = 1'b1; s_hit = 1'b0; step();
    set_idle(); repeat (3) step();
    s_rst = 1'b1; step();
    set_idle(); s_rdone = 1'b1; step();
    chk("rst_miss_en_f", {31'd0, bus.en_f}, 32'd1);
    chk("rst_miss_cnt", bus.stall_cycles, 32'd0);
    s_rdone = 1'b0; step();
    chk("stray_done_en_f", {31'd0, bus.en_f}, 32'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      s_rst   = ($urandom_range(0, 99) == 0);
      s_rs1   = 5'($urandom_range(0, 3));
      s_rs2   = 5'($urandom_range(0, 3));
      s_rd    = 5'($urandom_range(0, 3));
      s_rsrc  = 2'($urandom_range(0, 3));
      s_rw    = ($urandom_range(0, 3) != 0);
      s_ve    = ($urandom_range(0, 3) != 0);
      s_pc    = ($urandom_range(0, 5) == 0);
      s_mreq  = ($urandom_range(0, 3) == 0);
      s_hit   = ($urandom_range(0, 3) != 0);
      s_rdone = ($urandom_range(0, 7) == 0);
      step();
    end

    set_idle(); step();
    for (int g = 0; g < 10 && q.size() > 0; g++) @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
